// File: rtl/fp_sub_pkg.sv
// Shared types and constants for the sequential single-precision subtractor.
// The unpack struct carries everything captured from an operand pair at accept.
package fp_sub_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    OP,
    NORM,
    DONE
  } state_t;

  localparam logic [7:0]  EXP_MAX   = 8'hFF;
  localparam logic [31:0] QNAN      = 32'h7FC00000;
  localparam int          MANT_W    = 24;
  localparam int          ALIGN_CAP = 24;

  typedef struct packed {
    logic              sign;     // sign of the final result
    logic              eff_sub;  // 1: subtract magnitudes, 0: add them
    logic              special;  // an operand has exponent 8'hFF
    logic [7:0]        exp_x;    // exponent of the larger magnitude
    logic [MANT_W-1:0] mant_x;   // larger magnitude mantissa with hidden bit
    logic [MANT_W-1:0] mant_y;   // smaller magnitude mantissa with hidden bit
    logic [4:0]        shift;    // alignment distance, clamped
  } unpack_t;

endpackage

// File: rtl/fp_sub_if.sv
// Operand/result handshake bundle of the sequential subtractor.
// master drives operands and out_ready; slave is the arithmetic block.
interface fp_sub_if;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        Exception;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output a_operand, b_operand, in_valid, out_ready,
    input  in_ready, result, Exception, out_valid
  );

  modport slave (
    input  a_operand, b_operand, in_valid, out_ready,
    output in_ready, result, Exception, out_valid
  );
endinterface

// File: rtl/fp_sub_unpack.sv
// Combinational front end: field extraction, special detect, magnitude swap,
// effective operation, result sign and clamped alignment distance.
module fp_sub_unpack
  import fp_sub_pkg::*;
(
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  output unpack_t     fields
);

  localparam logic [4:0] SHIFT_CAP = 5'(ALIGN_CAP);

  logic [31:0]       ops    [2];
  logic              sign_f [2];
  logic [7:0]        exp_f  [2];
  logic [MANT_W-1:0] mant_f [2];
  logic              a_larger;
  logic [7:0]        exp_diff;

  assign ops[0] = a_operand;
  assign ops[1] = b_operand;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_field
      assign sign_f[gi] = ops[gi][31];
      assign exp_f[gi]  = ops[gi][30:23];
      // No denormals: a zero exponent means the value is zero.
      assign mant_f[gi] = (exp_f[gi] == 8'h00) ? '0 : {1'b1, ops[gi][22:0]};
    end
  endgenerate

  // Ties keep a as X, so equal magnitudes subtract to an exact zero.
  assign a_larger = (a_operand[30:0] >= b_operand[30:0]);
  assign exp_diff = a_larger ? (exp_f[0] - exp_f[1]) : (exp_f[1] - exp_f[0]);

  always_comb begin
    fields         = '0;
    fields.special = (exp_f[0] == EXP_MAX) || (exp_f[1] == EXP_MAX);
    fields.eff_sub = (sign_f[0] == sign_f[1]);
    fields.sign    = a_larger ? sign_f[0] : ~sign_f[1];
    fields.exp_x   = a_larger ? exp_f[0] : exp_f[1];
    fields.mant_x  = a_larger ? mant_f[0] : mant_f[1];
    fields.mant_y  = a_larger ? mant_f[1] : mant_f[0];
    fields.shift   = (exp_diff > 8'(ALIGN_CAP)) ? SHIFT_CAP : exp_diff[4:0];
  end

endmodule

// File: rtl/fp_sub_seq.sv
// Iterative IEEE-754 single-precision subtractor: one alignment or
// normalization bit per cycle, valid/ready on both sides, truncating.
module fp_sub_seq
  import fp_sub_pkg::*;
(
  input logic   clk,
  input logic   rst,
  fp_sub_if.slave bus
);

  unpack_t fields;

  state_t            state_reg,   state_next;
  logic              sign_reg,    sign_next;
  logic              eff_sub_reg, eff_sub_next;
  logic [7:0]        exp_reg,     exp_next;
  logic [MANT_W-1:0] mant_x_reg,  mant_x_next;
  logic [MANT_W-1:0] mant_y_reg,  mant_y_next;
  logic [4:0]        count_reg,   count_next;
  logic [MANT_W:0]   sum_reg,     sum_next;
  logic [31:0]       result_reg,  result_next;
  logic              exc_reg,     exc_next;
  logic [7:0]        exp_inc;

  fp_sub_unpack u_unpack (
    .a_operand (bus.a_operand),
    .b_operand (bus.b_operand),
    .fields    (fields)
  );

  assign exp_inc = exp_reg + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      sign_reg    <= 1'b0;
      eff_sub_reg <= 1'b0;
      exp_reg     <= '0;
      mant_x_reg  <= '0;
      mant_y_reg  <= '0;
      count_reg   <= '0;
      sum_reg     <= '0;
      result_reg  <= '0;
      exc_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sign_reg    <= sign_next;
      eff_sub_reg <= eff_sub_next;
      exp_reg     <= exp_next;
      mant_x_reg  <= mant_x_next;
      mant_y_reg  <= mant_y_next;
      count_reg   <= count_next;
      sum_reg     <= sum_next;
      result_reg  <= result_next;
      exc_reg     <= exc_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    sign_next    = sign_reg;
    eff_sub_next = eff_sub_reg;
    exp_next     = exp_reg;
    mant_x_next  = mant_x_reg;
    mant_y_next  = mant_y_reg;
    count_next   = count_reg;
    sum_next     = sum_reg;
    result_next  = result_reg;
    exc_next     = exc_reg;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          sign_next    = fields.sign;
          eff_sub_next = fields.eff_sub;
          exp_next     = fields.exp_x;
          mant_x_next  = fields.mant_x;
          mant_y_next  = fields.mant_y;
          count_next   = fields.shift;
          if (fields.special) begin
            exc_next    = 1'b1;
            result_next = QNAN;
            state_next  = DONE;
          end else begin
            exc_next   = 1'b0;
            state_next = ALIGN;
          end
        end
      end

      ALIGN: begin
        if (count_reg != 5'd0) begin
          mant_y_next = {1'b0, mant_y_reg[MANT_W-1:1]};
          count_next  = count_reg - 5'd1;
        end else begin
          state_next = OP;
        end
      end

      OP: begin
        // X >= Y in magnitude, so the subtraction never wraps.
        sum_next   = eff_sub_reg ? ({1'b0, mant_x_reg} - {1'b0, mant_y_reg})
                                 : ({1'b0, mant_x_reg} + {1'b0, mant_y_reg});
        state_next = NORM;
      end

      NORM: begin
        if (sum_reg[MANT_W]) begin
          sum_next   = {1'b0, sum_reg[MANT_W:1]};
          exp_next   = exp_inc;
          state_next = DONE;
          if (exp_inc == EXP_MAX) begin
            exc_next    = 1'b1;
            result_next = {sign_reg, EXP_MAX, 23'h0};
          end else begin
            result_next = {sign_reg, exp_inc, sum_reg[23:1]};
          end
        end else if (sum_reg == '0) begin
          result_next = 32'h0;
          state_next  = DONE;
        end else if (!sum_reg[MANT_W-1] && (exp_reg > 8'd1)) begin
          sum_next = {sum_reg[MANT_W-1:0], 1'b0};
          exp_next = exp_reg - 8'd1;
        end else if (!sum_reg[MANT_W-1]) begin
          result_next = 32'h0;
          state_next  = DONE;
        end else begin
          result_next = {sign_reg, exp_reg, sum_reg[22:0]};
          state_next  = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.result    = result_reg;
  assign bus.Exception = exc_reg;

endmodule

// File: tb/tb_fp_sub_seq.sv
// Directed bench for fp_sub_seq: arithmetic vectors with latency, exceptions,
// backpressure, ignored input while busy, and reset during alignment.
module tb_fp_sub_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fp_sub_if bus ();

  fp_sub_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        e;
    int          lat;
  } vec_t;

  // Presents one operand pair in IDLE and waits (bounded) for out_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic exc);
    bus.a_operand = a;
    bus.b_operand = b;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    res = bus.result;
    exc = bus.Exception;
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", bus.result); end
    checks++; if (bus.Exception !== 1'b0) begin errors++; $display("FAIL reset_exception: got %b expected 0", bus.Exception); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    vec_t        v [11];
    int          lat;
    logic [31:0] res;
    logic        exc;
    v = '{
      '{32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 5},   // 3 - 1
      '{32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 4},   // exact cancel
      '{32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 4},   // carry path
      '{32'h3FC00000, 32'h3FA00000, 32'h3E800000, 1'b0, 6},   // two left shifts
      '{32'h3F800000, 32'h40400000, 32'hC0000000, 1'b0, 5},   // b larger, sign flip
      '{32'h00C00000, 32'h00800000, 32'h00000000, 1'b0, 4},   // underflow flush
      '{32'h3F800000, 32'h30800000, 32'h3F800000, 1'b0, 28},  // k clamped to 24
      '{32'h00000000, 32'h3F800000, 32'hBF800000, 1'b0, 28},  // zero minuend
      '{32'h7F800000, 32'h3F800000, 32'h7FC00000, 1'b1, 1},   // Inf operand
      '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 4},   // exponent overflow
      '{32'h3F800000, 32'h7FC00000, 32'h7FC00000, 1'b1, 1}    // NaN subtrahend
    };
    for (int i = 0; i < 11; i++) begin
      run_op(v[i].a, v[i].b, lat, res, exc);
      $display("op %0d: %h - %h -> %h exc=%b lat=%0d", i, v[i].a, v[i].b, res, exc, lat);
      checks++; if (res !== v[i].r) begin errors++; $display("FAIL arith_result[%0d]: got %h expected %h", i, res, v[i].r); end
      checks++; if (exc !== v[i].e) begin errors++; $display("FAIL arith_exception[%0d]: got %b expected %b", i, exc, v[i].e); end
      checks++; if (lat != v[i].lat) begin errors++; $display("FAIL arith_latency[%0d]: got %0d expected %0d", i, lat, v[i].lat); end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [31:0] res;
    logic        exc;
    run_op(32'h40400000, 32'h3F800000, lat, res, exc);
    // Offer operands while busy; they must not be taken.
    bus.a_operand = 32'h7F800000;
    bus.b_operand = 32'h3F800000;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid[%0d]: got %b expected 1", c, bus.out_valid); end
      checks++; if (bus.result !== 32'h40000000) begin errors++; $display("FAIL hold_result[%0d]: got %h expected 40000000", c, bus.result); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", c, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    release_out();
    $display("backpressure: released after 10 held cycles, result %h", res);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    int          lat;
    logic [31:0] res;
    logic        exc;
    bus.a_operand = 32'h3F800000;
    bus.b_operand = 32'h30800000;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL align_in_ready: got %b expected 0", bus.in_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL midrst_result: got %h expected 00000000", bus.result); end
    checks++; if (bus.Exception !== 1'b0) begin errors++; $display("FAIL midrst_exception: got %b expected 0", bus.Exception); end
    repeat (30) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_dropped: got %b expected 0", bus.out_valid); end
    run_op(32'h3FC00000, 32'h3FA00000, lat, res, exc);
    $display("after reset: 3fc00000 - 3fa00000 -> %h lat=%0d", res, lat);
    checks++; if (res !== 32'h3E800000) begin errors++; $display("FAIL postrst_result: got %h expected 3e800000", res); end
    checks++; if (lat != 6) begin errors++; $display("FAIL postrst_latency: got %0d expected 6", lat); end
    release_out();
  endtask

  initial begin
    bus.a_operand = '0;
    bus.b_operand = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
